// File: rtl/sccb_slave_regif.sv
// SCCB/I2C target with a 16-bit register pointer and 8-bit data, bridged to a
// parallel register-file port. SCL/SDA are oversampled, synchronized and glitch filtered.
module sccb_slave_regif #(
  parameter logic [6:0]  DEV_ADDR = 7'h3C,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic        clk_24M,
  input  logic        camera_rstn,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rdata,
  output logic        busy,
  output logic        cfg_done
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_AH, S_AH_ACK, S_AL, S_AL_ACK,
    S_WD, S_WD_ACK, S_RD, S_RD_MACK, S_IGNORE
  } state_t;

  // Index 0 carries SCL, index 1 carries SDA.
  logic [1:0]         sync1_q, sync2_q, filt_q, filt_d, prev_q;
  logic [1:0][CW-1:0] cnt_q, cnt_d;

  state_t      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d, addr_hi_q, addr_hi_d, wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  rd_pipe_q, rd_pipe_d;
  logic        wr_en_q, wr_en_d, rd_en_q, rd_en_d, inc_q, inc_d;
  logic        busy_q, busy_d, cfg_done_q, cfg_done_d, wrote_q, wrote_d;
  logic        sda_oe_q, sda_oe_d, rw_q, rw_d, mack_q, mack_d;

  logic       scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] byte_nxt;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign scl_rise = filt_q[0] & ~prev_q[0];
  assign scl_fall = ~filt_q[0] & prev_q[0];
  assign start_ev = ~filt_q[1] & prev_q[1] & filt_q[0];
  assign stop_ev  = filt_q[1] & ~prev_q[1] & filt_q[0];
  assign byte_nxt = {shift_q[6:0], filt_q[1]};

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    addr_hi_d  = addr_hi_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    rd_pipe_d  = {rd_pipe_q[0], 1'b0};
    inc_d      = 1'b0;
    busy_d     = busy_q;
    cfg_done_d = 1'b0;
    wrote_d    = wrote_q;
    sda_oe_d   = sda_oe_q;
    rw_d       = rw_q;
    mack_d     = mack_q;

    if (inc_q) addr_d = addr_q + 16'd1;
    // Read data lands two cycles after the request; drive its MSB right away.
    if (rd_pipe_q[1]) begin
      shift_d  = reg_rdata;
      sda_oe_d = ~reg_rdata[7];
      bitcnt_d = '0;
      addr_d   = addr_q + 16'd1;
    end

    if (start_ev) begin
      state_d   = S_DEV;
      bitcnt_d  = '0;
      sda_oe_d  = 1'b0;
      rd_pipe_d = '0;
      busy_d    = 1'b1;
      if (!busy_q) wrote_d = 1'b0;
    end else if (stop_ev) begin
      state_d    = S_IDLE;
      sda_oe_d   = 1'b0;
      rd_pipe_d  = '0;
      busy_d     = 1'b0;
      cfg_done_d = wrote_q;
      wrote_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_DEV, S_AH, S_AL, S_WD: begin
          if (scl_rise) begin
            shift_d  = byte_nxt;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              unique case (state_q)
                S_DEV: begin
                  rw_d    = byte_nxt[0];
                  state_d = (byte_nxt[7:1] == DEV_ADDR) ? S_DEV_ACK : S_IGNORE;
                end
                S_AH: begin
                  addr_hi_d = byte_nxt;
                  state_d   = S_AH_ACK;
                end
                S_AL: begin
                  addr_d  = {addr_hi_q, byte_nxt};
                  state_d = S_AL_ACK;
                end
                default: begin
                  wdata_d = byte_nxt;
                  wr_en_d = 1'b1;
                  inc_d   = 1'b1;
                  wrote_d = 1'b1;
                  state_d = S_WD_ACK;
                end
              endcase
            end
          end
        end
        // First SCL fall asserts the ACK, the second (end of 9th pulse) releases it.
        S_DEV_ACK, S_AH_ACK, S_AL_ACK, S_WD_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              bitcnt_d = '0;
              unique case (state_q)
                S_DEV_ACK: begin
                  if (rw_q) begin
                    state_d   = S_RD;
                    rd_en_d   = 1'b1;
                    rd_pipe_d = 2'b01;
                  end else begin
                    state_d = S_AH;
                  end
                end
                S_AH_ACK: state_d = S_AL;
                default:  state_d = S_WD;
              endcase
            end
          end
        end
        S_RD: begin
          if (scl_fall && rd_pipe_q == 2'b00) begin
            if (bitcnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              mack_d   = 1'b0;
              state_d  = S_RD_MACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end
        end
        S_RD_MACK: begin
          if (scl_rise) begin
            if (filt_q[1]) state_d = S_IGNORE;
            else           mack_d  = 1'b1;
          end else if (scl_fall && mack_q) begin
            mack_d    = 1'b0;
            state_d   = S_RD;
            rd_en_d   = 1'b1;
            rd_pipe_d = 2'b01;
          end
        end
        S_IDLE, S_IGNORE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_24M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      filt_q     <= '1;
      prev_q     <= '1;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      addr_hi_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_pipe_q  <= '0;
      inc_q      <= 1'b0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      wrote_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b0;
    end else begin
      sync1_q    <= {i2c_sdat, i2c_sclk};
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      prev_q     <= filt_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      addr_hi_q  <= addr_hi_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      rd_pipe_q  <= rd_pipe_d;
      inc_q      <= inc_d;
      busy_q     <= busy_d;
      cfg_done_q <= cfg_done_d;
      wrote_q    <= wrote_d;
      sda_oe_q   <= sda_oe_d;
      rw_q       <= rw_d;
      mack_q     <= mack_d;
    end
  end

  assign i2c_sdat  = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign busy      = busy_q;
  assign cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_sccb_slave_regif.sv
// Bench for sccb_slave_regif: bit-banged SCCB master, register-file model and
// scoreboard queues for write strobes, read requests and read-back bytes.
module tb_sccb_slave_regif;

  localparam int unsigned Q = 10;

  logic        clk_24M = 1'b0;
  logic        camera_rstn = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [7:0]  reg_rdata = 8'hC3;
  wire         sda_bus;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_wr_en, reg_rd_en, busy, cfg_done;

  assign sda_bus = m_sda ? 1'bz : 1'b0;
  pullup (sda_bus);

  always #20 clk_24M = ~clk_24M;

  sccb_slave_regif #(.DEV_ADDR(7'h3C), .FILT_LEN(3)) dut (
    .clk_24M    (clk_24M),
    .camera_rstn(camera_rstn),
    .i2c_sclk   (m_scl),
    .i2c_sdat   (sda_bus),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr_en  (reg_wr_en),
    .reg_rd_en  (reg_rd_en),
    .reg_rdata  (reg_rdata),
    .busy       (busy),
    .cfg_done   (cfg_done)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_byte[$];
  int          n_cmp = 0, n_bad = 0;
  int          wr_cnt = 0, rd_cnt = 0, cfg_cnt = 0, slv_low = 0;
  wr_t         e_wr;
  logic        pend = 1'b0;
  logic [7:0]  pend_val = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h300A: return 8'h56;
      16'h300B: return 8'h40;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Register model presents read data only in the window the slave must latch it.
  always @(negedge clk_24M) begin
    reg_rdata = pend ? pend_val : 8'hC3;
    pend      = reg_rd_en;
    pend_val  = mem_rd(reg_addr);
    if (reg_wr_en) begin
      wr_cnt++;
      if (exp_wr.size() > 0) begin
        e_wr = exp_wr.pop_front();
        chk("wr_addr", reg_addr, e_wr.a);
        chk("wr_data", reg_wdata, e_wr.d);
      end
    end
    if (reg_rd_en) begin
      rd_cnt++;
      if (exp_rd.size() > 0) chk("rd_addr", reg_addr, exp_rd.pop_front());
    end
    if (cfg_done) cfg_cnt++;
    if (m_sda && sda_bus === 1'b0) slv_low++;
  end

  task automatic wt(input int unsigned n);
    repeat (n) @(negedge clk_24M);
  endtask

  task automatic start_c();
    m_sda = 1'b1; wt(Q);
    m_scl = 1'b1; wt(Q);
    m_sda = 1'b0; wt(Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic stop_c();
    m_sda = 1'b0; wt(Q);
    m_scl = 1'b1; wt(Q);
    m_sda = 1'b1; wt(Q);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    m_sda = b;
    wt(Q / 2);
    if (glitch) begin
      m_scl = 1'b1; wt(2);
      m_scl = 1'b0;
    end
    wt(Q);
    m_scl = 1'b1; wt(2 * Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wt(Q);
    m_scl = 1'b1; wt(Q);
    b = sda_bus;  wt(Q);
    m_scl = 1'b0; wt(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, input logic ack_exp, input logic [7:0] gmask,
                       input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(d[i], gmask[i]);
    recv_bit(a);
    chk(tag, a, !ack_exp);
  endtask

  task automatic rbyte(input logic ack);
    logic [7:0] d;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(!ack, 1'b0);
    if (exp_byte.size() > 0) chk("rd_byte", d, exp_byte.pop_front());
    else chk("rd_byte_unexpected", d, 8'hxx);
  endtask

  task automatic begin_t();
    wr_cnt = 0; rd_cnt = 0; cfg_cnt = 0; slv_low = 0;
  endtask

  task automatic end_t(input int ew, input int er, input int ec);
    stop_c();
    wt(3 * Q);
    chk("busy_after_stop", busy, 1'b0);
    chk("wr_count", wr_cnt, ew);
    chk("rd_count", rd_cnt, er);
    chk("cfg_done_count", cfg_cnt, ec);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wt(5);
    chk("rst_addr", reg_addr, 16'h0000);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_wr_en", reg_wr_en, 1'b0);
    chk("rst_rd_en", reg_rd_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_done", cfg_done, 1'b0);
    chk("rst_sda", sda_bus, 1'b1);
    camera_rstn = 1'b1;
    wt(2 * Q);

    // Single write
    begin_t();
    exp_wr.push_back('{16'h3008, 8'h82});
    start_c();
    chk("busy_start", busy, 1'b1);
    wbyte(8'h78, 1'b1, 8'h00, "ack_dev");
    wbyte(8'h30, 1'b1, 8'h00, "ack_ah");
    wbyte(8'h08, 1'b1, 8'h00, "ack_al");
    wbyte(8'h82, 1'b1, 8'h00, "ack_wd");
    end_t(1, 0, 1);
    chk("addr_after_single", reg_addr, 16'h3009);

    // Burst write
    begin_t();
    exp_wr.push_back('{16'h3800, 8'h00});
    exp_wr.push_back('{16'h3801, 8'h00});
    exp_wr.push_back('{16'h3802, 8'h04});
    start_c();
    wbyte(8'h78, 1'b1, 8'h00, "ack_dev");
    wbyte(8'h38, 1'b1, 8'h00, "ack_ah");
    wbyte(8'h00, 1'b1, 8'h00, "ack_al");
    wbyte(8'h00, 1'b1, 8'h00, "ack_wd0");
    wbyte(8'h00, 1'b1, 8'h00, "ack_wd1");
    wbyte(8'h04, 1'b1, 8'h00, "ack_wd2");
    end_t(3, 0, 1);

    // Pointer write, repeated start, two-byte read
    begin_t();
    exp_rd.push_back(16'h300A);
    exp_rd.push_back(16'h300B);
    exp_byte.push_back(8'h56);
    exp_byte.push_back(8'h40);
    start_c();
    wbyte(8'h78, 1'b1, 8'h00, "ack_dev");
    wbyte(8'h30, 1'b1, 8'h00, "ack_ah");
    wbyte(8'h0A, 1'b1, 8'h00, "ack_al");
    start_c();
    chk("busy_sr", busy, 1'b1);
    wbyte(8'h79, 1'b1, 8'h00, "ack_dev_rd");
    rbyte(1'b1);
    rbyte(1'b0);
    end_t(0, 2, 0);
    chk("addr_after_read", reg_addr, 16'h300C);

    // Wrong device address
    begin_t();
    start_c();
    chk("busy_wrong_addr", busy, 1'b1);
    wbyte(8'h42, 1'b0, 8'h00, "nack_dev");
    wbyte(8'h30, 1'b0, 8'h00, "nack_ignored");
    end_t(0, 0, 0);
    chk("slave_sda_low_cycles", slv_low, 0);

    // STOP after 5 bits of a data byte: address-only update
    begin_t();
    start_c();
    wbyte(8'h78, 1'b1, 8'h00, "ack_dev");
    wbyte(8'h12, 1'b1, 8'h00, "ack_ah");
    wbyte(8'h34, 1'b1, 8'h00, "ack_al");
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    end_t(0, 0, 0);
    chk("addr_only", reg_addr, 16'h1234);

    // Wrap at 0xFFFF, with 2-cycle SCL glitches inside the second data byte
    begin_t();
    exp_wr.push_back('{16'hFFFF, 8'h11});
    exp_wr.push_back('{16'h0000, 8'h22});
    start_c();
    wbyte(8'h78, 1'b1, 8'h00, "ack_dev");
    wbyte(8'hFF, 1'b1, 8'h00, "ack_ah");
    wbyte(8'hFF, 1'b1, 8'h00, "ack_al");
    wbyte(8'h11, 1'b1, 8'h00, "ack_wd0");
    wbyte(8'h22, 1'b1, 8'h5A, "ack_wd1_glitch");
    end_t(2, 0, 1);
    chk("addr_after_wrap", reg_addr, 16'h0001);

    // Reset asserted while the slave drives ACK
    begin_t();
    exp_wr.push_back('{16'h00AA, 8'h55});
    start_c();
    wbyte(8'h78, 1'b1, 8'h00, "ack_dev");
    wbyte(8'h00, 1'b1, 8'h00, "ack_ah");
    wbyte(8'hAA, 1'b1, 8'h00, "ack_al");
    for (int i = 7; i >= 0; i--) send_bit(((8'h55 >> i) & 8'h01) != 8'h00, 1'b0);
    m_sda = 1'b1; wt(Q);
    m_scl = 1'b1; wt(Q);
    chk("ack_before_rst", sda_bus, 1'b0);
    camera_rstn = 1'b0;
    #1;
    chk("rst_mid_sda", sda_bus, 1'b1);
    chk("rst_mid_addr", reg_addr, 16'h0000);
    chk("rst_mid_wdata", reg_wdata, 8'h00);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_strobes", {reg_wr_en, reg_rd_en, cfg_done}, 3'b000);
    wt(Q);
    m_scl = 1'b0; wt(Q);
    camera_rstn = 1'b1; wt(Q);
    end_t(1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sccb_slave_regif.md
Name: sccb_slave_regif

Overview:
- SCCB/I2C target (responder) for the camera configuration bus.
- Decodes the 16-bit-register-address / 8-bit-data transactions that our configuration master issues (device write address 0x78, read address 0x79).
- Converts them into a simple parallel register-file port.
- Used as the camera-side model in system simulation and as an FPGA-hosted configurable peripheral. Oversamples SCL/SDA on the system clock.

Parameters:
DEV_ADDR, 7'h3C, 7-bit target address (0x78 write / 0x79 read on the wire)
FILT_LEN, 3, clk_24M samples a synchronized SCL/SDA level must hold before it is accepted (glitch filter)

Ports:
clk_24M  in  1  system clock, 24 MHz
camera_rstn  in  1  asynchronous active-low reset
i2c_sclk  in  1  bus clock from master
i2c_sdat  inout  1  open-drain data; driven only to 0, otherwise Z
reg_addr  out  16  current register pointer
reg_wdata  out  8  write data, valid with reg_wr_en
reg_wr_en  out  1  one-cycle write strobe
reg_rd_en  out  1  one-cycle read request for reg_addr
reg_rdata  in  8  read data; sampled exactly 2 clk_24M cycles after reg_rd_en
busy  out  1  high from accepted START to STOP
cfg_done  out  1  one-cycle pulse on STOP if ≥1 register was written since START

Behaviour:
- Reset (async, camera_rstn=0): i2c_sdat=Z, reg_addr=0, reg_wdata=0, reg_wr_en=0, reg_rd_en=0, busy=0, cfg_done=0, state=IDLE. Reset mid-transfer releases SDA immediately.
- Input path: 2-FF synchronizer, then FILT_LEN-sample filter on both SCL and SDA. Edge and event detection runs on the filtered levels.
  - START/Sr = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Data bits are sampled on SCL rise, MSB first.
- Driving SDA: slave changes SDA only ≥1 clk after a filtered SCL fall, and holds it until the next filtered SCL fall.
- States:
  - IDLE
  - DEV (shift 8 bits)
  - DEV_ACK
  - AH (addr high)
  - AH_ACK
  - AL (addr low)
  - AL_ACK
  - WD (write data)
  - WD_ACK
  - RD (shift out)
  - RD_MACK (sample master ACK)
  - IGNORE
- Transitions:
  - START from any state → DEV, bit counter cleared, busy=1.
  - STOP from any state → IDLE. SDA released, busy=0, partial byte discarded.
  - DEV complete:
    - Address ≠ DEV_ADDR → IGNORE (no ACK).
    - Address match with R/W=0 → DEV_ACK, then AH.
    - Address match with R/W=1 → DEV_ACK, then RD.
  - AH_ACK → AL. AL_ACK → WD. reg_addr is loaded with {hi,lo} at the 8th AL bit.
  - WD: at the 8th bit sampled, reg_wdata=byte and reg_wr_en pulses one cycle. reg_addr increments on the following cycle. Then WD_ACK → WD (burst).
  - RD entry (at the SCL fall ending DEV_ACK or RD_MACK):
    - reg_rd_en pulses.
    - reg_rdata is latched into the shift register 2 cycles later.
    - The MSB is driven before the next SCL rise.
    - reg_addr increments after the latch.
  - RD_MACK: SDA released and sampled on SCL rise. 0 (ACK) → RD. 1 (NACK) → IGNORE until STOP/Sr.
  - IGNORE: SDA stays Z.
- ACK: SDA driven 0 for exactly the 9th SCL pulse of each acknowledged byte (DEV match, AH, AL, WD).
- Wrap: reg_addr 0xFFFF increments to 0x0000.
- Repeated start keeps reg_addr. This is how write-pointer-then-read works.
- Simultaneous events: START/STOP detection takes priority over bit sampling in the same cycle. reg_wr_en never pulses for a byte interrupted by START/STOP.
- Address-only writes (STOP after AL_ACK) update reg_addr, produce no reg_wr_en, and cfg_done stays 0.
- Minimum SCL high/low: ≥ FILT_LEN+4 clk_24M cycles. The 20 kHz configuration clock far exceeds this.

Test Plan:
- Single write: START, 0x78, 0x30, 0x08, 0x82, STOP.
  - ACK on all 4 bytes.
  - One reg_wr_en with reg_addr=0x3008, reg_wdata=0x82.
  - cfg_done pulses once after STOP, busy returns 0.
- Burst write: 0x78, 0x38, 0x00, 0x00, 0x00, 0x04, STOP → three strobes: (0x3800,0x00), (0x3801,0x00), (0x3802,0x04).
- Read: 0x78, 0x30, 0x0A, Sr, 0x79; model returns 0x56@0x300A and 0x40@0x300B; master ACKs byte 1 and NACKs byte 2.
  - SDA carries 0x56 then 0x40.
  - reg_rd_en pulses twice.
  - No reg_wr_en, cfg_done=0.
- Wrong address: START, 0x42, 0x30, STOP → SDA never low, no strobes, busy 1→0.
- Robustness: STOP after 5 bits of a WD byte → no strobe. camera_rstn low mid-ACK → SDA Z within the same cycle, all outputs at reset values.
- Wrap and glitch:
  - Write at 0xFFFF with 2 data bytes → second strobe at 0x0000.
  - 2-cycle SCL glitch with FILT_LEN=3 → no bit counted.
